// File: rtl/d_latch.sv
// Gated D latch: Q follows D while en is high, holds while en is low.
// Building block for the master-slave flip-flop variant.
`timescale 1ns/1ps

module d_latch #(
    parameter int WIDTH = 1
) (
    input  logic             en,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Q_bar
);

    always_latch begin
        if (en) begin
            Q <= D;
        end
    end

    assign Q_bar = ~Q;

endmodule

// File: rtl/d_flip_flop_reset.sv
// Rising-edge D flip-flop with synchronous active-high reset and a complementary output.
// STRUCTURAL=1 builds the same cell from a master-slave pair of gated D latches.
`timescale 1ns/1ps

module d_flip_flop_reset #(
    parameter int WIDTH      = 1,
    parameter int TPD        = 0,
    parameter bit STRUCTURAL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Q_bar
);

    // TPD is meaningful only for timing-annotated netlist simulation; this RTL is zero-delay.
    localparam int TPD_UNUSED = TPD;

    generate
        if (STRUCTURAL) begin : g_master_slave
            logic             clk_n;
            logic [WIDTH-1:0] master_d;
            logic [WIDTH-1:0] master_q;
            logic [WIDTH-1:0] master_qn_unused;

            assign clk_n    = ~clk;
            // Reset is folded into the master input, so it only takes effect at the edge that closes the master.
            assign master_d = rst ? '0 : D;

            d_latch #(.WIDTH(WIDTH)) u_master (
                .en    (clk_n),
                .D     (master_d),
                .Q     (master_q),
                .Q_bar (master_qn_unused)
            );

            d_latch #(.WIDTH(WIDTH)) u_slave (
                .en    (clk),
                .D     (master_q),
                .Q     (Q),
                .Q_bar (Q_bar)
            );
        end else begin : g_behavioural
            always_ff @(posedge clk) begin
                if (rst) begin
                    Q <= '0;
                end else begin
                    Q <= D;
                end
            end

            // Complement is derived from Q rather than registered, so the two can never disagree.
            assign Q_bar = ~Q;
        end
    endgenerate

endmodule

// File: tb/tb_d_flip_flop_reset.sv
// Scoreboard bench: behavioural and master-slave variants side by side, directed cases then a random soak.
`timescale 1ns/1ps

module tb_d_flip_flop_reset;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic [W-1:0] d;
    logic [W-1:0] q0, qb0, q1, qb1;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] held;
    bit           have_held = 0;
    bit           stim_done = 0;

    d_flip_flop_reset #(.WIDTH(W), .TPD(0), .STRUCTURAL(1'b0)) dut_beh (
        .clk   (clk),
        .rst   (rst),
        .D     (d),
        .Q     (q0),
        .Q_bar (qb0)
    );

    d_flip_flop_reset #(.WIDTH(W), .TPD(0), .STRUCTURAL(1'b1)) dut_str (
        .clk   (clk),
        .rst   (rst),
        .D     (d),
        .Q     (q1),
        .Q_bar (qb1)
    );

    // First rising edge at 10 ns, then 100 ns period (rising edges at 10, 110, 210, ...).
    initial begin
        clk = 1'b0;
        #10 clk = 1'b1;
        forever #50 clk = ~clk;
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, req);
        end
    endtask

    // Reference model: what each edge must store is simply "reset ? zero : D".
    always @(posedge clk) begin
        if (!stim_done) exp_q.push_back(rst ? '0 : d);
    end

    // Monitor: after each rising edge plus settling, both variants must show the queued value.
    always @(posedge clk) begin
        logic [W-1:0] e;
        #1;
        if (!stim_done || exp_q.size() != 0) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL scoreboard_underflow t=%0t actual=empty required=entry", $time);
            end else begin
                e = exp_q.pop_front();
                check("edge_q_beh",    q0,  e);
                check("edge_q_str",    q1,  e);
                check("edge_qbar_beh", qb0, ~e);
                check("edge_qbar_str", qb1, ~e);
                held      = e;
                have_held = 1'b1;
            end
        end
    end

    // Mid-cycle: Q must still hold the last captured value whatever D and rst did since.
    always @(negedge clk) begin
        if (have_held && !stim_done) begin
            check("hold_q_beh",    q0,  held);
            check("hold_q_str",    q1,  held);
            check("hold_qbar_beh", qb0, ~held);
            check("hold_qbar_str", qb1, ~held);
        end
    end

    initial begin
        d   = '0;
        rst = 1'b0;

        // Power-up, first edge at 10 captures D=0.
        #40  d = 8'hA5;            // t=40
        #100 d = 8'h3C;            // t=140, after edge 110 captured A5
        #100 d = 8'hFF;            // t=240, edge 210 captured 3C
        #100 rst = 1'b1;           // t=340, edge 310 captured FF; negedge 360 must still see FF
        #100 d = 8'h5A;            // t=440, edge 410 reset to 0; rst held so edge 510 keeps 0
        #100 begin rst = 1'b0; d = 8'h11; end  // t=540
        #30  rst = 1'b1;           // t=570, clk low phase 560..610
        #20  rst = 1'b0;           // t=590, pulse dropped before edge 610, so 11 is captured
        #30;                       // t=620

        // Random soak: D every 101 ns, rst every 150 ns, 3000 ns.
        fork
            begin
                for (int i = 0; i < 30; i++) begin
                    d = W'($urandom);
                    #101;
                end
            end
            begin
                for (int j = 0; j < 20; j++) begin
                    rst = ($urandom_range(0, 3) == 0);
                    #150;
                end
            end
        join

        #5 stim_done = 1'b1;
        #200;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
